mipi_rx_packet_parser: RTL
==========================

// Module: mipi_rx_packet_parser
// PURPOSE
//  Receive-side counterpart of the MIPI TX packet path: parses CSI-2 packets delivered by the
//  MIPI RX IP in the RxByteClkHS domain into vsync/hsync strobes and an RGB888 pixel stream.
//  Unpacks 32-bit payload words into 24-bit pixels (4 bytes/cycle in, 1-2 pixels/cycle out),
//  writes them to the downstream line FIFO, and flags length/format/overflow errors.
// PARAMETERS
//  DT_FS     6'h00  frame-start short packet data type
//  DT_FE     6'h01  frame-end short packet data type
//  DT_PIXEL  6'h3E  RGB888 long packet data type
//  H_ACTIVE  1920   expected pixels per line
//  V_ACTIVE  1080   expected lines per frame
// PORTS
//  RxByteClkHS      in   1   byte clock; the only clock
//  rstn             in   1   asynchronous active-low reset
//  rx_hdr_valid     in   1   1-cycle strobe: packet header valid
//  rx_hdr_dt        in   6   header data type
//  rx_hdr_wc        in   16  long: payload byte count; short: data field (ignored)
//  rx_payload_en    in   1   payload word valid
//  rx_payload_last  in   1   last payload word of packet (with rx_payload_en)
//  rx_payload       in   32  payload; [7:0] = first byte on the wire
//  fifo_full        in   1   downstream FIFO cannot accept a write this cycle
//  err_clr          in   1   clears all sticky error flags
//  rx_vsync         out  1   1-cycle pulse per frame start
//  rx_hsync         out  1   1-cycle pulse per accepted pixel line
//  pix_wr           out  1   FIFO write strobe
//  pix_dual         out  1   both pixel slots valid (else only [23:0])
//  pix_data         out  48  [23:0]=pixel n, [47:24]=pixel n+1; pixel={b2,b1,b0}
//  frame_active     out  1   high between FS and FE
//  line_count       out  11  pixel lines received in current frame
//  err_wc/err_line/err_frame/err_ovf  out 1 each  sticky errors
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; residual=0; counters=0. Reset mid-packet abandons packet.
//  FSM IDLE: header FS -> vsync, frame_active=1, line_count=0; FE -> frame_active=0,
//   err_frame if line_count!=V_ACTIVE; DT_PIXEL && frame_active -> hsync, PAYLOAD;
//   DT_PIXEL && !frame_active -> DROP; other long types -> DROP; other short types ignored.
//  PAYLOAD: consume words; on rx_payload_last -> IDLE, line_count+1, length checks. DROP:
//   discard words until rx_payload_last -> IDLE.
//  Last-word byte count = wc mod 4 (0 means 4); bytes above that are ignored.
//  Gearbox phase p (residual bytes 0/1/2), per accepted word: p0: 1 pixel, keep 1 byte;
//   p1: 1 pixel, keep 2; p2: 2 pixels (pix_dual=1), keep 0. Repeats every 3 words/4 pixels.
//  Latency: pix_wr/pix_data exactly 1 cycle after the rx_payload_en cycle; rx_vsync/rx_hsync
//   1 cycle after the header strobe, so hsync precedes the first pix_wr of the line.
//  fifo_full when a write is due: write suppressed, err_ovf set, gearbox still advances.
//  Line end: nonzero residual (wc not multiple of 3) -> err_wc, residual discarded;
//   pixel count != H_ACTIVE -> err_line. Residual and pixel count reset at every header.
//  Header while in PAYLOAD/DROP: current packet truncated, err_wc, new header processed.
//  rx_payload_en in IDLE: ignored. FS while frame_active: err_frame, frame restarts.
//  Header strobe and payload word same cycle: word belongs to old packet, then header taken.
//  Error flags sticky; err_clr clears them; a set event in the same cycle wins over err_clr.
//  line_count saturates at 2047.
// TESTING
//  FS, 1080 lines DT 0x3E wc=5760 (1440 words), FE -> 1 vsync, 1080 hsync, 1920 px/line, no err.
//  Words 0x44332211,0x88776655,0xCCBBAA99 -> pix 0x332211; 0x665544; 0x998877 + 0xCCBBAA dual.
//  wc=5759 line -> last word uses 3 bytes, residual 2 -> err_wc, 1919 px written, err_line.
//  fifo_full for 1 cycle mid-line -> that write absent, err_ovf=1 until err_clr pulse.
//  Pixel packet before FS -> no hsync, no pix_wr; FS after 3 lines then FE -> err_frame=1.
//  New header after 10 words, no last -> err_wc, new packet parsed normally; rstn low mid-line -> all 0.

Source files
------------

// File: rtl/mipi_rx_packet_parser_if.sv
// CSI-2 receive bus from the MIPI RX IP: header strobes and 32-bit payload words.
// The RX IP is the master; the packet parser is the slave.
interface mipi_rx_packet_parser_if;
    logic        rx_hdr_valid;
    logic [5:0]  rx_hdr_dt;
    logic [15:0] rx_hdr_wc;
    logic        rx_payload_en;
    logic        rx_payload_last;
    logic [31:0] rx_payload;

    modport master (
        output rx_hdr_valid, rx_hdr_dt, rx_hdr_wc,
        output rx_payload_en, rx_payload_last, rx_payload
    );

    modport slave (
        input rx_hdr_valid, rx_hdr_dt, rx_hdr_wc,
        input rx_payload_en, rx_payload_last, rx_payload
    );
endinterface

// File: rtl/mipi_rx_packet_parser.sv
// CSI-2 RX packet parser: turns FS/FE/RGB888 packets into sync strobes and a 1-2 pixel/cycle
// stream, unpacking 32-bit payload words through a 3-byte gearbox, with sticky error flags.
module mipi_rx_packet_parser #(
    parameter logic [5:0] DT_FS    = 6'h00,
    parameter logic [5:0] DT_FE    = 6'h01,
    parameter logic [5:0] DT_PIXEL = 6'h3E,
    parameter int         H_ACTIVE = 1920,
    parameter int         V_ACTIVE = 1080
) (
    input  logic                          RxByteClkHS,
    input  logic                          rstn,
    mipi_rx_packet_parser_if.slave        rx,
    input  logic                          fifo_full,
    input  logic                          err_clr,
    output logic                          rx_vsync,
    output logic                          rx_hsync,
    output logic                          pix_wr,
    output logic                          pix_dual,
    output logic [47:0]                   pix_data,
    output logic                          frame_active,
    output logic [10:0]                   line_count,
    output logic                          err_wc,
    output logic                          err_line,
    output logic                          err_frame,
    output logic                          err_ovf
);
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DROP} state_e;

    typedef struct packed {
        logic wc;
        logic line;
        logic frame;
        logic ovf;
    } err_t;

    state_e      state_q, state_d;
    logic        frame_q, frame_d;
    logic [10:0] line_q, line_d;
    logic [15:0] res_q, res_d;          // leftover bytes, oldest in [7:0]
    logic [1:0]  res_cnt_q, res_cnt_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] words_q, words_d;
    logic [15:0] wc_q, wc_d;
    logic        vsync_q, vsync_d;
    logic        hsync_q, hsync_d;
    logic        wr_q, wr_d;
    logic        dual_q, dual_d;
    logic [47:0] data_q, data_d;
    err_t        err_q, err_d, err_set;

    logic [2:0]  word_bytes;
    logic [31:0] word_masked;
    logic [47:0] gb_buf;
    logic [2:0]  gb_tot;
    logic [16:0] exp_words;

    assign exp_words = ({1'b0, wc_q} + 17'd3) >> 2;

    // Gearbox: append the valid bytes of this word behind the residual bytes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        word_bytes = 3'd4;
        if (rx.rx_payload_last && wc_q[1:0] != 2'd0) begin
            word_bytes = {1'b0, wc_q[1:0]};
        end
        case (word_bytes)
            3'd1:    word_masked = {24'b0, rx.rx_payload[7:0]};
            3'd2:    word_masked = {16'b0, rx.rx_payload[15:0]};
            3'd3:    word_masked = {8'b0, rx.rx_payload[23:0]};
            default: word_masked = rx.rx_payload;
        endcase
        gb_buf = ({16'b0, word_masked} << {res_cnt_q, 3'b000}) | {32'b0, res_q};
        gb_tot = {1'b0, res_cnt_q} + word_bytes;
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        line_d    = line_q;
        res_d     = res_q;
        res_cnt_d = res_cnt_q;
        pix_cnt_d = pix_cnt_q;
        words_d   = words_q;
        wc_d      = wc_q;
        vsync_d   = 1'b0;
        hsync_d   = 1'b0;
        wr_d      = 1'b0;
        dual_d    = 1'b0;
        data_d    = data_q;
        err_set   = '0;
        err_set.ovf = wr_q && fifo_full;

        // A payload word in the same cycle as a header belongs to the old packet.
        if (rx.rx_payload_en && state_q == S_PAYLOAD) begin
            words_d = words_q + 16'd1;
            if (gb_tot >= 3'd6) begin
                wr_d      = 1'b1;
                dual_d    = 1'b1;
                data_d    = gb_buf;
                res_d     = '0;
                res_cnt_d = 2'd0;
                pix_cnt_d = pix_cnt_q + 16'd2;
            end else if (gb_tot >= 3'd3) begin
                wr_d      = 1'b1;
                data_d    = {24'b0, gb_buf[23:0]};
                res_d     = gb_buf[39:24];
                res_cnt_d = 2'(gb_tot - 3'd3);
                pix_cnt_d = pix_cnt_q + 16'd1;
            end else begin
                res_d     = gb_buf[15:0];
                res_cnt_d = gb_tot[1:0];
            end
            if (rx.rx_payload_last) begin
                state_d     = S_IDLE;
                line_d      = (line_q == 11'h7FF) ? line_q : line_q + 11'd1;
                err_set.wc  = (res_cnt_d != 2'd0) || ({1'b0, words_d} != exp_words);
                err_set.line = (pix_cnt_d != 16'(H_ACTIVE));
                res_d       = '0;
                res_cnt_d   = 2'd0;
                pix_cnt_d   = '0;
                words_d     = '0;
            end
        end else if (rx.rx_payload_en && state_q == S_DROP && rx.rx_payload_last) begin
            state_d = S_IDLE;
        end

        if (rx.rx_hdr_valid) begin
            if (state_q != S_IDLE && !(rx.rx_payload_en && rx.rx_payload_last)) begin
                err_set.wc = 1'b1;
            end
            state_d   = S_IDLE;
            res_d     = '0;
            res_cnt_d = 2'd0;
            pix_cnt_d = '0;
            words_d   = '0;
            wc_d      = rx.rx_hdr_wc;
            if (rx.rx_hdr_dt == DT_FS) begin
                vsync_d = 1'b1;
                if (frame_q) err_set.frame = 1'b1;
                frame_d = 1'b1;
                line_d  = '0;
            end else if (rx.rx_hdr_dt == DT_FE) begin
                frame_d = 1'b0;
                if (line_d != 11'(V_ACTIVE)) err_set.frame = 1'b1;
            end else if (rx.rx_hdr_dt == DT_PIXEL) begin
                if (frame_q) begin
                    hsync_d = 1'b1;
                    state_d = S_PAYLOAD;
                end else begin
                    state_d = S_DROP;
                end
            end else if (rx.rx_hdr_dt >= 6'h10) begin
                state_d = S_DROP;
            end
        end

        // A set event in the same cycle takes priority over the clear.
        err_d = err_clr ? err_set : err_t'(err_set | err_q);
    end

    always_ff @(posedge RxByteClkHS or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            frame_q   <= 1'b0;
            line_q    <= '0;
            res_q     <= '0;
            res_cnt_q <= 2'd0;
            pix_cnt_q <= '0;
            words_q   <= '0;
            wc_q      <= '0;
            vsync_q   <= 1'b0;
            hsync_q   <= 1'b0;
            wr_q      <= 1'b0;
            dual_q    <= 1'b0;
            data_q    <= '0;
            err_q     <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            frame_q   <= frame_d;
            line_q    <= line_d;
            res_q     <= res_d;
            res_cnt_q <= res_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            words_q   <= words_d;
            wc_q      <= wc_d;
            vsync_q   <= vsync_d;
            hsync_q   <= hsync_d;
            wr_q      <= wr_d;
            dual_q    <= dual_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    // The write is dropped in the cycle the FIFO reports full; err_ovf records it.
    assign pix_wr       = wr_q && !fifo_full;
    assign pix_dual     = dual_q;
    assign pix_data     = data_q;
    assign rx_vsync     = vsync_q;
    assign rx_hsync     = hsync_q;
    assign frame_active = frame_q;
    assign line_count   = line_q;
    assign err_wc       = err_q.wc;
    assign err_line     = err_q.line;
    assign err_frame    = err_q.frame;
    assign err_ovf      = err_q.ovf;
endmodule
